vector_alu_sched: RTL and testbench

// - Shares one vector ALU (1-cycle, valid/ready target + result ports) among NUM_REQ requesters.
// - Round-robin arbitration on issue; an in-order tag FIFO returns each result to its requester via rsp_id.
// - A drain FSM quiesces the ALU on request (flush) before reconfiguration or power-down.

---
 rtl/vector_alu_pkg.sv | 37 +++
 rtl/valu_tag_fifo.sv | 71 +++++++
 rtl/vector_alu_sched.sv | 198 +++++++++++++++++++
 tb/tb_vector_alu_sched.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vector_alu_pkg.sv
// ============================================================================
// Package : vector_alu_pkg
// Purpose : Shared types for the vector ALU scheduler: ALU opcode encoding,
//           condition-status bit positions and the scheduler state encoding.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package vector_alu_pkg;

  // ALU opcode encoding; zero is reserved as "no operation".
  typedef enum logic [3:0] {
    OP_ADD = 4'd1,
    OP_SUB = 4'd2,
    OP_AND = 4'd3,
    OP_OR  = 4'd4,
    OP_XOR = 4'd5,
    OP_SHL = 4'd6,
    OP_SHR = 4'd7,
    OP_ROR = 4'd8
  } valu_op_e;

  // Bit positions inside the 3-bit condition-status word {carry, overflow, zero}.
  localparam int c_CSR_ZERO  = 0;
  localparam int c_CSR_OVF   = 1;
  localparam int c_CSR_CARRY = 2;

  // Scheduler operating mode.
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_IDLE  = 2'd2
  } sched_state_e;

endpackage

`default_nettype wire

// File: rtl/valu_tag_fifo.sv
// ============================================================================
// Module  : valu_tag_fifo
// Purpose : Synchronous FIFO holding the requester index of every operation
//           in flight, so results can be routed back in issue order.
// Ports   : clk, srst_n     clock, synchronous active-low reset
//           i_push/i_wdata  enqueue a tag (ignored when full)
//           i_pop           dequeue the head tag (ignored when empty)
//           o_rdata         head tag (stale when empty)
//           o_full/o_empty  occupancy flags
//           o_count         number of stored tags
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module valu_tag_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     srst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rptr];

  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  // Storage needs no reset: an entry is only read after it was written.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!srst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/vector_alu_sched.sv
// ============================================================================
// Module  : vector_alu_sched
// Purpose : Shares one single-cycle vector ALU among NUM_REQ requesters with
//           round-robin issue, routes results back via an in-order tag FIFO
//           and provides a flush/drain handshake for quiescing the ALU.
// Ports   : clk, srst_n                  clock, synchronous active-low reset
//           i_req_valid/o_req_ready      per-requester handshake
//           i_req_t0/t1/oper             packed per-requester operands/opcode
//           i_req_lock                   grant hold request (lock build only)
//           o_alu_t0/t1/oper/valid       issue side towards the ALU
//           i_alu_ready                  ALU accepts the issued op
//           i_alu_data/csr/rvalid        ALU result side
//           o_alu_rready                 result accept towards the ALU
//           o_rsp_data/csr/id/valid      result to requesters, i_rsp_ready accept
//           i_flush/o_flush_done         drain request / drained pulse
//           o_tag_err                    sticky: result arrived with no tag
// Config  : VALU_SCHED_LOCK_EN - enables grant locking through i_req_lock.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module vector_alu_sched
  import vector_alu_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 10,
  parameter int OPER_WIDTH = 10,
  parameter int TAG_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          srst_n,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  output logic [NUM_REQ-1:0]            o_req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_t0,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_t1,
  input  logic [NUM_REQ*OPER_WIDTH-1:0] i_req_oper,
  input  logic [NUM_REQ-1:0]            i_req_lock,
  output logic [DATA_WIDTH-1:0]         o_alu_t0,
  output logic [DATA_WIDTH-1:0]         o_alu_t1,
  output logic [OPER_WIDTH-1:0]         o_alu_oper,
  output logic                          o_alu_valid,
  input  logic                          i_alu_ready,
  input  logic [DATA_WIDTH-1:0]         i_alu_data,
  input  logic [2:0]                    i_alu_csr,
  input  logic                          i_alu_rvalid,
  output logic                          o_alu_rready,
  output logic [DATA_WIDTH-1:0]         o_rsp_data,
  output logic [2:0]                    o_rsp_csr,
  output logic [$clog2(NUM_REQ)-1:0]    o_rsp_id,
  output logic                          o_rsp_valid,
  input  logic                          i_rsp_ready,
  input  logic                          i_flush,
  output logic                          o_flush_done,
  output logic                          o_tag_err
);

  localparam int IDW = $clog2(NUM_REQ);

  sched_state_e              r_state;
  sched_state_e              w_state_nxt;
  logic [IDW-1:0]            r_rr_ptr;
  logic                      r_tag_err;
  logic                      w_rr_any;
  logic [IDW-1:0]            w_rr_idx;
  logic                      w_gnt_any;
  logic [IDW-1:0]            w_gnt_idx;
  logic                      w_lock_hold;
  logic                      w_can_issue;
  logic                      w_issue;
  logic                      w_pop;
  logic [IDW-1:0]            w_head;
  logic                      w_fifo_full;
  logic                      w_fifo_empty;
  logic [$clog2(TAG_DEPTH):0] w_unused_count;

  // Round-robin search: first valid requester at or after r_rr_ptr.
  always_comb begin
    int k;
    k        = 0;
    w_rr_any = 1'b0;
    w_rr_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = int'(r_rr_ptr) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      if (!w_rr_any && i_req_valid[k]) begin
        w_rr_any = 1'b1;
        w_rr_idx = IDW'(k);
      end
    end
  end

`ifdef VALU_SCHED_LOCK_EN
  logic           r_lock_vld;
  logic [IDW-1:0] r_lock_owner;

  assign w_lock_hold = r_lock_vld & i_req_lock[r_lock_owner];

  // While held, only the owner may be granted, even if it is idle.
  assign w_gnt_any = w_lock_hold ? i_req_valid[r_lock_owner] : w_rr_any;
  assign w_gnt_idx = w_lock_hold ? r_lock_owner : w_rr_idx;

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      r_lock_vld   <= 1'b0;
      r_lock_owner <= '0;
    end else if (i_flush) begin
      r_lock_vld   <= 1'b0;
    end else if (!w_lock_hold) begin
      // A fresh lock is taken by whichever requester issues with its lock set.
      r_lock_vld   <= w_issue & i_req_lock[w_gnt_idx];
      r_lock_owner <= w_gnt_idx;
    end
  end
`else
  logic w_unused_lock;

  assign w_unused_lock = ^i_req_lock;
  assign w_lock_hold   = 1'b0;
  assign w_gnt_any     = w_rr_any;
  assign w_gnt_idx     = w_rr_idx;
`endif

  // Issue is suppressed in the cycle flush is raised so DRAIN starts clean.
  assign w_can_issue = (r_state == ST_RUN) & ~i_flush & w_gnt_any & ~w_fifo_full;
  assign o_alu_valid = w_can_issue;
  assign w_issue     = w_can_issue & i_alu_ready;

  always_comb begin
    o_req_ready = '0;
    if (w_issue) o_req_ready[w_gnt_idx] = 1'b1;
  end

  assign o_alu_t0   = i_req_t0[w_gnt_idx*DATA_WIDTH +: DATA_WIDTH];
  assign o_alu_t1   = i_req_t1[w_gnt_idx*DATA_WIDTH +: DATA_WIDTH];
  assign o_alu_oper = i_req_oper[w_gnt_idx*OPER_WIDTH +: OPER_WIDTH];

  // Result path is a straight pass-through; only the id comes from the FIFO.
  assign w_pop        = i_alu_rvalid & i_rsp_ready & ~w_fifo_empty;
  assign o_alu_rready = i_rsp_ready;
  assign o_rsp_data   = i_alu_data;
  assign o_rsp_csr    = i_alu_csr;
  assign o_rsp_valid  = i_alu_rvalid;
  assign o_rsp_id     = w_fifo_empty ? '0 : w_head;
  assign o_tag_err    = r_tag_err;

  valu_tag_fifo #(
    .WIDTH (IDW),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk     (clk),
    .srst_n  (srst_n),
    .i_push  (w_issue),
    .i_wdata (w_gnt_idx),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_unused_count)
  );

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      r_state   <= ST_RUN;
      r_rr_ptr  <= '0;
      r_tag_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      // The pointer stays frozen while a lock is being honoured.
      if (w_issue && !w_lock_hold) begin
        r_rr_ptr <= (w_gnt_idx == IDW'(NUM_REQ-1)) ? '0 : w_gnt_idx + IDW'(1);
      end
      if (i_alu_rvalid && w_fifo_empty) r_tag_err <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    o_flush_done = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (i_flush) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_fifo_empty) begin
          w_state_nxt  = ST_IDLE;
          o_flush_done = 1'b1;
        end
      end
      ST_IDLE: begin
        if (!i_flush) w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_vector_alu_sched.sv
// ============================================================================
// Module  : tb_vector_alu_sched
// Purpose : Directed self-checking bench for vector_alu_sched. A small
//           buffered ALU model answers every issued operation.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_vector_alu_sched;

  localparam int NR = 4;
  localparam int DW = 10;
  localparam int OW = 10;

  logic              clk;
  logic              srst_n;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*DW-1:0]  req_t0;
  logic [NR*DW-1:0]  req_t1;
  logic [NR*OW-1:0]  req_oper;
  logic [NR-1:0]     req_lock;
  logic [DW-1:0]     alu_t0;
  logic [DW-1:0]     alu_t1;
  logic [OW-1:0]     alu_oper;
  logic              alu_valid;
  logic              alu_ready;
  logic [DW-1:0]     alu_data;
  logic [2:0]        alu_csr;
  logic              alu_rvalid;
  logic              alu_rready;
  logic [DW-1:0]     rsp_data;
  logic [2:0]        rsp_csr;
  logic [1:0]        rsp_id;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              flush;
  logic              flush_done;
  logic              tag_err;

  int vectors;
  int miscompares;

  // ALU model: results queue up in issue order until consumed.
  logic [DW+2:0] m_mem [8];
  logic [2:0]    m_wp;
  logic [2:0]    m_rp;
  logic          m_rvalid;
  logic          alu_auto;
  logic          force_rvalid;

  vector_alu_sched #(
    .NUM_REQ    (NR),
    .DATA_WIDTH (DW),
    .OPER_WIDTH (OW),
    .TAG_DEPTH  (4)
  ) dut (
    .clk          (clk),
    .srst_n       (srst_n),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_t0     (req_t0),
    .i_req_t1     (req_t1),
    .i_req_oper   (req_oper),
    .i_req_lock   (req_lock),
    .o_alu_t0     (alu_t0),
    .o_alu_t1     (alu_t1),
    .o_alu_oper   (alu_oper),
    .o_alu_valid  (alu_valid),
    .i_alu_ready  (alu_ready),
    .i_alu_data   (alu_data),
    .i_alu_csr    (alu_csr),
    .i_alu_rvalid (alu_rvalid),
    .o_alu_rready (alu_rready),
    .o_rsp_data   (rsp_data),
    .o_rsp_csr    (rsp_csr),
    .o_rsp_id     (rsp_id),
    .o_rsp_valid  (rsp_valid),
    .i_rsp_ready  (rsp_ready),
    .i_flush      (flush),
    .o_flush_done (flush_done),
    .o_tag_err    (tag_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Returns {carry, overflow, zero, data}.
  function automatic logic [DW+2:0] alu_f(input logic [OW-1:0] op,
                                          input logic [DW-1:0] a,
                                          input logic [DW-1:0] b);
    logic [DW:0]   s;
    logic [DW-1:0] d;
    logic          c;
    logic          v;
    s = '0;
    c = 1'b0;
    v = 1'b0;
    if (op == 10'd1) begin
      s = {1'b0, a} + {1'b0, b};
      d = s[DW-1:0];
      c = s[DW];
      v = (a[DW-1] == b[DW-1]) && (d[DW-1] != a[DW-1]);
    end else if (op == 10'd2) begin
      d = a - b;
      c = (a < b);
      v = (a[DW-1] != b[DW-1]) && (d[DW-1] != a[DW-1]);
    end else begin
      d = a ^ b;
    end
    return {c, v, (d == '0), d};
  endfunction

  always @(posedge clk) begin
    if (!srst_n) begin
      m_wp <= '0;
      m_rp <= '0;
    end else begin
      if (alu_auto && m_rvalid && rsp_ready) m_rp <= m_rp + 3'd1;
      if (alu_valid && alu_ready) begin
        m_mem[m_wp] <= alu_f(alu_oper, alu_t0, alu_t1);
        m_wp        <= m_wp + 3'd1;
      end
    end
  end

  assign m_rvalid   = (m_wp != m_rp);
  assign alu_rvalid = alu_auto ? m_rvalid : force_rvalid;
  assign alu_data   = alu_auto ? m_mem[m_rp][DW-1:0] : '0;
  assign alu_csr    = alu_auto ? m_mem[m_rp][DW+2:DW] : 3'b000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vectors      = 0;
    miscompares  = 0;
    srst_n       = 1'b0;
    req_valid    = '0;
    req_t0       = '0;
    req_t1       = '0;
    req_oper     = '0;
    req_lock     = '0;
    alu_ready    = 1'b1;
    rsp_ready    = 1'b1;
    flush        = 1'b0;
    alu_auto     = 1'b1;
    force_rvalid = 1'b0;

    // ---- reset state
    tick();
    tick();
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_alu_valid", 32'(alu_valid), 32'h0);
    chk("rst_flush_done", 32'(flush_done), 32'h0);
    chk("rst_tag_err", 32'(tag_err), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    srst_n = 1'b1;
    tick();

    // ---- req0 ADD 3+4, req2 SUB 9-9
    req_t0[0*DW +: DW]   = 10'd3;
    req_t1[0*DW +: DW]   = 10'd4;
    req_oper[0*OW +: OW] = 10'd1;
    req_t0[2*DW +: DW]   = 10'd9;
    req_t1[2*DW +: DW]   = 10'd9;
    req_oper[2*OW +: OW] = 10'd2;
    req_valid = 4'b0101;
    #1;
    chk("t1_ready0", 32'(req_ready), 32'h1);
    chk("t1_alu_t0", 32'(alu_t0), 32'd3);
    chk("t1_alu_t1", 32'(alu_t1), 32'd4);
    chk("t1_alu_oper", 32'(alu_oper), 32'd1);
    tick();
    req_valid = 4'b0100;
    #1;
    chk("t1_ready2", 32'(req_ready), 32'h4);
    chk("t1_alu_t0_b", 32'(alu_t0), 32'd9);
    chk("t1_rsp_id0", 32'(rsp_id), 32'd0);
    chk("t1_rsp_data7", 32'(rsp_data), 32'd7);
    tick();
    req_valid = 4'b0000;
    #1;
    chk("t1_rsp_id2", 32'(rsp_id), 32'd2);
    chk("t1_rsp_data0", 32'(rsp_data), 32'd0);
    chk("t1_rsp_csr", 32'(rsp_csr), 32'b001);
    tick();
    chk("t1_rsp_empty", 32'(rsp_valid), 32'h0);

    // ---- all four valid from a fresh pointer: 0,1,2,3,0
    srst_n = 1'b0;
    tick();
    srst_n = 1'b1;
    for (int k = 0; k < NR; k++) begin
      req_t0[k*DW +: DW]   = 10'(k + 1);
      req_t1[k*DW +: DW]   = 10'd0;
      req_oper[k*OW +: OW] = 10'd1;
    end
    req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("rr_grant", 32'(req_ready), 32'(4'b0001 << (i % 4)));
      chk("rr_alu_t0", 32'(alu_t0), 32'((i % 4) + 1));
      tick();
    end
    req_valid = 4'b0000;
    tick();
    tick();

    // ---- backpressure: four in flight, fifth stalls until a pop
    rsp_ready = 1'b0;
    req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("full_fill", 32'(req_ready), 32'(4'b0001 << ((i + 1) % 4)));
      tick();
    end
    #1;
    chk("full_stall_ready", 32'(req_ready), 32'h0);
    chk("full_stall_valid", 32'(alu_valid), 32'h0);
    tick();
    chk("full_stall_hold", 32'(req_ready), 32'h0);
    rsp_ready = 1'b1;
    #1;
    chk("full_prepop", 32'(req_ready), 32'h0);
    chk("full_head_id", 32'(rsp_id), 32'd1);
    tick();
    chk("full_resume", 32'(req_ready), 32'h2);
    chk("full_next_id", 32'(rsp_id), 32'd2);
    tick();
    req_valid = 4'b0000;
    for (int i = 0; i < 6; i++) tick();
    chk("full_drained", 32'(rsp_valid), 32'h0);

    // ---- flush with two in flight
    rsp_ready = 1'b0;
    req_valid = 4'b0011;
    #1;
    chk("fl_issue_a", 32'(req_ready), 32'h1);
    tick();
    chk("fl_issue_b", 32'(req_ready), 32'h2);
    tick();
    flush = 1'b1;
    #1;
    chk("fl_noissue", 32'(alu_valid), 32'h0);
    chk("fl_noready", 32'(req_ready), 32'h0);
    tick();
    flush = 1'b0;
    #1;
    chk("drain_noissue", 32'(alu_valid), 32'h0);
    chk("drain_done_lo", 32'(flush_done), 32'h0);
    rsp_ready = 1'b1;
    tick();
    chk("drain_one_left", 32'(flush_done), 32'h0);
    tick();
    chk("drain_done_pulse", 32'(flush_done), 32'h1);
    tick();
    chk("idle_done_lo", 32'(flush_done), 32'h0);
    chk("idle_noissue", 32'(alu_valid), 32'h0);
    flush = 1'b1;
    #1;
    chk("idle_flush_noissue", 32'(alu_valid), 32'h0);
    tick();
    flush = 1'b0;
    #1;
    chk("idle_hold", 32'(alu_valid), 32'h0);
    tick();
    chk("run_again", 32'(req_ready), 32'h1);
    tick();
    req_valid = 4'b0000;
    tick();
    tick();

    // ---- result with no tag outstanding
    alu_auto     = 1'b0;
    force_rvalid = 1'b1;
    #1;
    chk("terr_rsp_id", 32'(rsp_id), 32'd0);
    chk("terr_pre", 32'(tag_err), 32'h0);
    tick();
    force_rvalid = 1'b0;
    #1;
    chk("terr_set", 32'(tag_err), 32'h1);
    tick();
    tick();
    chk("terr_sticky", 32'(tag_err), 32'h1);
    srst_n = 1'b0;
    tick();
    srst_n = 1'b1;
    #1;
    chk("terr_cleared", 32'(tag_err), 32'h0);
    alu_auto = 1'b1;

`ifdef VALU_SCHED_LOCK_EN
    // ---- lock: req1 holds the grant for three issues
    tick();
    req_valid = 4'b0001;
    #1;
    chk("lk_pre", 32'(req_ready), 32'h1);
    tick();
    req_valid = 4'b0111;
    req_lock  = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("lk_hold", 32'(req_ready), 32'h2);
      tick();
    end
    req_lock = 4'b0000;
    #1;
    chk("lk_release", 32'(req_ready), 32'h4);
    tick();
    req_valid = 4'b0000;
    tick();
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
